pc_sequencer: RTL and testbench

//  Owns the program counter and sequences each instruction through fetch -> execute -> PC update.
//  It consumes o_take/target from the branch unit and handshakes with instruction memory.
//  It traps on misaligned redirect targets and counts retired instructions.

---
 rtl/pc_sequencer_pkg.sv | 19 +
 rtl/pc_sequencer_retire_counter.sv | 19 +
 rtl/pc_sequencer.sv | 85 ++++++++
 tb/tb_pc_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: datapath width, FSM state codes and
// the branch-target alignment helper.
package pc_sequencer_pkg;

  localparam int unsigned DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    StBoot  = 2'd0,
    StFetch = 2'd1,
    StExec  = 2'd2,
    StTrap  = 2'd3
  } pcseq_state_e;

  // Instructions are word aligned; any nonzero low bit in a redirect is a trap.
  function automatic logic is_word_aligned(input logic [DATA_WIDTH-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/pc_sequencer_retire_counter.sv
// Free-running count of retired instructions; wraps at 2^CNT_WIDTH.
module pc_sequencer_retire_counter #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner: sequences fetch -> execute -> PC update, traps on
// misaligned redirects and counts retired instructions.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned           CNT_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  imem_ack,
  input  logic                  stall,
  input  logic                  take,
  input  logic [DATA_WIDTH-1:0] target,
  output logic [DATA_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] pc_plus4,
  output logic                  imem_req,
  output logic                  instr_valid,
  output logic                  misaligned,
  output logic [CNT_WIDTH-1:0]  retired
);

  if (RESET_VECTOR[1:0] != 2'b00) begin : gen_bad_reset_vector
    $error("pc_sequencer: RESET_VECTOR must be 4-byte aligned");
  end

  pcseq_state_e state_q;
  logic         bad_redirect;
  logic         retire;

  assign pc_plus4     = pc + DATA_WIDTH'(4);
  assign bad_redirect = take && !is_word_aligned(target);
  // take/target only matter on the cycle EXEC actually completes.
  assign retire       = (state_q == StExec) && !stall && !bad_redirect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StBoot;
      pc          <= RESET_VECTOR;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      misaligned  <= 1'b0;
    end else begin
      unique case (state_q)
        StBoot: begin
          state_q  <= StFetch;
          imem_req <= 1'b1;
        end
        StFetch: begin
          if (imem_ack) begin
            state_q     <= StExec;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
          end
        end
        StExec: begin
          if (!stall) begin
            instr_valid <= 1'b0;
            if (bad_redirect) begin
              state_q    <= StTrap;
              misaligned <= 1'b1;
            end else begin
              state_q  <= StFetch;
              imem_req <= 1'b1;
              pc       <= take ? target : pc_plus4;
            end
          end
        end
        StTrap: begin
          state_q <= StTrap;
        end
      endcase
    end
  end

  pc_sequencer_retire_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_retire_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (retire),
    .count (retired)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized and directed bench for pc_sequencer against a behavioural model
// of the fetch/execute/trap rules.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_ack, stall, take;
  logic [31:0] target;

  logic [31:0] pc, pc_plus4;
  logic        imem_req, instr_valid, misaligned;
  logic [31:0] retired;

  logic [31:0] pc_w, pc_plus4_w;
  logic        imem_req_w, instr_valid_w, misaligned_w;
  logic [1:0]  retired_w;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_ack    (imem_ack),
    .stall       (stall),
    .take        (take),
    .target      (target),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .imem_req    (imem_req),
    .instr_valid (instr_valid),
    .misaligned  (misaligned),
    .retired     (retired)
  );

  pc_sequencer #(
    .RESET_VECTOR (32'hFFFF_FFFC),
    .CNT_WIDTH    (2)
  ) dut_w (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_ack    (imem_ack),
    .stall       (stall),
    .take        (take),
    .target      (target),
    .pc          (pc_w),
    .pc_plus4    (pc_plus4_w),
    .imem_req    (imem_req_w),
    .instr_valid (instr_valid_w),
    .misaligned  (misaligned_w),
    .retired     (retired_w)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model of the main instance: which phase of the instruction we are in.
  logic [31:0] m_pc;
  int unsigned m_ret;
  bit          m_boot, m_fetch, m_exec, m_trap;

  task automatic model_reset();
    m_pc = 32'h0; m_ret = 0;
    m_boot = 1; m_fetch = 0; m_exec = 0; m_trap = 0;
  endtask

  task automatic model_edge();
    if (m_boot) begin
      m_boot = 0; m_fetch = 1;
    end else if (m_fetch) begin
      if (imem_ack) begin m_fetch = 0; m_exec = 1; end
    end else if (m_exec && !stall) begin
      m_exec = 0;
      if (take && target[1:0] != 2'b00) begin
        m_trap = 1;
      end else begin
        m_pc  = take ? target : m_pc + 32'd4;
        m_ret = m_ret + 1;
        m_fetch = 1;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    n_cmp++;
    if (pc !== m_pc) begin
      n_bad++; $display("FAIL %s pc: got %h want %h", tag, pc, m_pc);
    end
    n_cmp++;
    if (pc_plus4 !== m_pc + 32'd4) begin
      n_bad++; $display("FAIL %s pc_plus4: got %h want %h", tag, pc_plus4, m_pc + 32'd4);
    end
    n_cmp++;
    if (imem_req !== m_fetch) begin
      n_bad++; $display("FAIL %s imem_req: got %b want %b", tag, imem_req, m_fetch);
    end
    n_cmp++;
    if (instr_valid !== m_exec) begin
      n_bad++; $display("FAIL %s instr_valid: got %b want %b", tag, instr_valid, m_exec);
    end
    n_cmp++;
    if (misaligned !== m_trap) begin
      n_bad++; $display("FAIL %s misaligned: got %b want %b", tag, misaligned, m_trap);
    end
    n_cmp++;
    if (retired !== m_ret) begin
      n_bad++; $display("FAIL %s retired: got %0d want %0d", tag, retired, m_ret);
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; imem_ack = 0; stall = 0; take = 0; target = '0;
    model_reset();
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic goto_exec();
    take = 0; stall = 0; imem_ack = 1;
    for (int i = 0; i < 8 && !m_exec; i++) cycle("goto_exec");
    imem_ack = 0;
    n_cmp++;
    if (instr_valid !== 1'b1) begin
      n_bad++; $display("FAIL goto_exec instr_valid: got %b want 1", instr_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #3;
    apply_reset();
    n_cmp++;
    if (imem_req_w !== 1'b0 || pc_w !== 32'hFFFF_FFFC || retired_w !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_w: got req=%b pc=%h ret=%0d want req=0 pc=fffffffc ret=0",
               imem_req_w, pc_w, retired_w);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] fetched[$];
    apply_reset();
    imem_ack = 1;
    for (int i = 0; i < 7; i++) begin
      cycle("seq");
      if (imem_req === 1'b1) fetched.push_back(pc);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (fetched.size() <= i || fetched[i] !== 32'(i * 4)) begin
        n_bad++;
        $display("FAIL seq_fetch_pc[%0d]: got %h want %h", i,
                 (fetched.size() > i) ? fetched[i] : 32'hx, 32'(i * 4));
      end
    end
    n_cmp++;
    if (retired !== 32'd3) begin
      n_bad++; $display("FAIL seq_retired: got %0d want 3", retired);
    end
  endtask

  task automatic test_branch();
    logic [31:0] r0;
    goto_exec();
    r0 = retired;
    take = 1; target = 32'h100;
    cycle("branch");
    take = 0;
    n_cmp++;
    if (pc !== 32'h100 || retired !== r0 + 32'd1) begin
      n_bad++;
      $display("FAIL branch: got pc=%h ret=%0d want pc=00000100 ret=%0d", pc, retired, r0 + 1);
    end
  endtask

  task automatic test_stall();
    logic [31:0] pc0, r0;
    goto_exec();
    pc0 = pc; r0 = retired;
    stall = 1; take = 1; target = 32'h200;
    repeat (5) cycle("stall");
    n_cmp++;
    if (pc !== pc0 || retired !== r0 || instr_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL stall_hold: got pc=%h ret=%0d want pc=%h ret=%0d", pc, retired, pc0, r0);
    end
    stall = 0;
    cycle("stall_release");
    take = 0;
    n_cmp++;
    if (pc !== 32'h200) begin
      n_bad++; $display("FAIL stall_redirect: got pc=%h want 00000200", pc);
    end
  endtask

  task automatic test_trap();
    logic [31:0] pc0;
    goto_exec();
    pc0 = pc;
    take = 1; target = 32'h102;
    cycle("trap_enter");
    n_cmp++;
    if (misaligned !== 1'b1 || pc !== pc0) begin
      n_bad++; $display("FAIL trap_enter: got mis=%b pc=%h want mis=1 pc=%h", misaligned, pc, pc0);
    end
    for (int i = 0; i < 20; i++) begin
      imem_ack = 1'($urandom); stall = 1'($urandom); take = 1'($urandom);
      target = $urandom;
      cycle("trap_hold");
    end
    n_cmp++;
    if (pc !== pc0 || imem_req !== 1'b0 || instr_valid !== 1'b0 || misaligned !== 1'b1) begin
      n_bad++;
      $display("FAIL trap_hold: got pc=%h req=%b val=%b mis=%b want pc=%h req=0 val=0 mis=1",
               pc, imem_req, instr_valid, misaligned, pc0);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    imem_ack = 1;
    cycle("wrap");
    n_cmp++;
    if (pc_w !== 32'hFFFF_FFFC || pc_plus4_w !== 32'h0) begin
      n_bad++; $display("FAIL wrap_first: got pc=%h plus4=%h want fffffffc/00000000", pc_w, pc_plus4_w);
    end
    cycle("wrap"); cycle("wrap");
    n_cmp++;
    if (pc_w !== 32'h0 || imem_req_w !== 1'b1) begin
      n_bad++; $display("FAIL wrap_second_fetch: got pc=%h req=%b want 00000000/1", pc_w, imem_req_w);
    end
    repeat (8) cycle("wrap");
    n_cmp++;
    if (retired_w !== 2'd1) begin
      n_bad++; $display("FAIL wrap_counter: got %0d want 1", retired_w);
    end
    // Reset asserted in the middle of a fetch must drop the request at once.
    apply_reset();
    imem_ack = 0;
    cycle("midreset_fetch");
    n_cmp++;
    if (imem_req_w !== 1'b1) begin
      n_bad++; $display("FAIL midreset_pre: got req=%b want 1", imem_req_w);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (imem_req_w !== 1'b0 || pc_w !== 32'hFFFF_FFFC) begin
      n_bad++; $display("FAIL midreset: got req=%b pc=%h want 0/fffffffc", imem_req_w, pc_w);
    end
    check_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_delayed_ack();
    logic [31:0] pc0;
    apply_reset();
    imem_ack = 0;
    cycle("dack");
    pc0 = pc;
    repeat (3) begin
      cycle("dack_wait");
      n_cmp++;
      if (pc !== pc0 || imem_req !== 1'b1) begin
        n_bad++; $display("FAIL dack_stable: got pc=%h req=%b want pc=%h req=1", pc, imem_req, pc0);
      end
    end
    imem_ack = 1;
    cycle("dack_ack");
    stall = 1;
    repeat (3) cycle("dack_spurious");
    n_cmp++;
    if (instr_valid !== 1'b1 || imem_req !== 1'b0 || pc !== pc0) begin
      n_bad++;
      $display("FAIL dack_spurious: got val=%b req=%b pc=%h want 1/0/%h",
               instr_valid, imem_req, pc, pc0);
    end
    stall = 0; imem_ack = 0;
    cycle("dack_retire");
  endtask

  task automatic test_random();
    int trap_cycles;
    apply_reset();
    trap_cycles = 0;
    for (int i = 0; i < 500; i++) begin
      if (m_trap) trap_cycles++;
      if (trap_cycles > 3) begin
        trap_cycles = 0;
        apply_reset();
      end
      imem_ack = ($urandom_range(1, 0) == 0);
      stall    = ($urandom_range(3, 0) == 0);
      take     = ($urandom_range(2, 0) == 0);
      target   = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(15, 0) == 0) target[1:0] = 2'($urandom_range(3, 1));
      cycle("random");
    end
  endtask

  initial begin
    imem_ack = 0; stall = 0; take = 0; target = '0;
    model_reset();
    test_reset();
    test_sequential();
    test_branch();
    test_stall();
    test_trap();
    test_wrap();
    test_delayed_ack();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
